// File: rtl/mod_exp_engine.sv
// mod_exp_engine: sequential modular exponentiation, result = base^exp mod modulus.
// Left-to-right square-and-multiply. Every exponent bit costs one squaring and
// one multiply, so the run time does not depend on the operand values. Each
// modular multiply is a bit-serial shift/add/reduce loop of SIZE cycles.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   start_   request pulse, sampled only in IDLE
//   base_    message/base operand (SIZE bits)
//   exp_     exponent (SIZE bits)
//   mod_     modulus (SIZE bits)
//   result_  base^exp mod modulus, held until the next completion
//   msg_     copy of base_ captured when a start is accepted
//   busy_    high from acceptance through the cycle done_ is high
//   done_    single-cycle completion pulse
//   err_     accepted modulus was zero; held until the next acceptance
module mod_exp_engine #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_,
  input  logic [SIZE-1:0] base_,
  input  logic [SIZE-1:0] exp_,
  input  logic [SIZE-1:0] mod_,
  output logic [SIZE-1:0] result_,
  output logic [SIZE-1:0] msg_,
  output logic            busy_,
  output logic            done_,
  output logic            err_
);

  localparam int IW = $clog2(SIZE);
  localparam logic [IW-1:0]   TOP_IDX  = IW'(SIZE - 1);
  localparam logic [IW-1:0]   IDX_ONE  = IW'(1);
  localparam logic [IW-1:0]   IDX_ZERO = {IW{1'b0}};
  localparam logic [SIZE-1:0] OP_ZERO  = {SIZE{1'b0}};
  localparam logic [SIZE-1:0] OP_ONE   = SIZE'(1);
  localparam logic [SIZE:0]   P_ZERO   = {(SIZE+1){1'b0}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REDUCE = 3'd1,
    SQR    = 3'd2,
    MUL    = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t          state_r;
  logic [SIZE-1:0] base_r, exp_r, mod_r;
  logic [SIZE-1:0] acc_r, bq_r, t_r;
  logic [SIZE:0]   p_r;      // partial product, always < modulus between steps
  logic [IW-1:0]   i_r;      // exponent bit index
  logic [IW-1:0]   j_r;      // multiplier bit index inside one modular multiply

  logic [SIZE-1:0] mm_a_s, mm_b_s;
  logic [SIZE:0]   mod_ext_s, dbl_s, red_s, sum_s, p_next_s;
  logic [SIZE-1:0] mul_pick_s;

  // Operand routing for the shared modular multiplier, chosen by phase.
  always_comb begin
    mm_a_s = OP_ZERO;
    mm_b_s = OP_ZERO;
    case (state_r)
      REDUCE: begin
        mm_a_s = base_r;   // base * 1 mod m folds an oversized base into range
        mm_b_s = OP_ONE;
      end
      SQR: begin
        mm_a_s = acc_r;
        mm_b_s = acc_r;
      end
      MUL: begin
        mm_a_s = t_r;
        mm_b_s = bq_r;
      end
      default: begin
        mm_a_s = OP_ZERO;
        mm_b_s = OP_ZERO;
      end
    endcase
  end

  // One shift/add/reduce step of the bit-serial modular multiply.
  always_comb begin
    mod_ext_s = {1'b0, mod_r};
    dbl_s     = {p_r[SIZE-1:0], 1'b0};
    if (dbl_s >= mod_ext_s) begin
      red_s = dbl_s - mod_ext_s;
    end else begin
      red_s = dbl_s;
    end
    if (mm_a_s[j_r]) begin
      sum_s = red_s + {1'b0, mm_b_s};
    end else begin
      sum_s = red_s;
    end
    if (sum_s >= mod_ext_s) begin
      p_next_s = sum_s - mod_ext_s;
    end else begin
      p_next_s = sum_s;
    end
    // The multiply is always computed; the exponent bit only selects which
    // product survives, keeping the timing independent of the exponent.
    if (exp_r[i_r]) begin
      mul_pick_s = p_next_s[SIZE-1:0];
    end else begin
      mul_pick_s = t_r;
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      base_r  <= OP_ZERO;
      exp_r   <= OP_ZERO;
      mod_r   <= OP_ZERO;
      acc_r   <= OP_ZERO;
      bq_r    <= OP_ZERO;
      t_r     <= OP_ZERO;
      p_r     <= P_ZERO;
      i_r     <= IDX_ZERO;
      j_r     <= IDX_ZERO;
      result_ <= OP_ZERO;
      msg_    <= OP_ZERO;
      busy_   <= 1'b0;
      done_   <= 1'b0;
      err_    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_) begin
            base_r <= base_;
            exp_r  <= exp_;
            mod_r  <= mod_;
            msg_   <= base_;
            busy_  <= 1'b1;
            p_r    <= P_ZERO;
            i_r    <= TOP_IDX;
            j_r    <= TOP_IDX;
            if (mod_ == OP_ZERO) begin
              err_    <= 1'b1;
              result_ <= OP_ZERO;
              done_   <= 1'b1;
              acc_r   <= OP_ZERO;
              state_r <= DONE;
            end else begin
              err_    <= 1'b0;
              // Anything mod 1 is 0, including x^0.
              acc_r   <= (mod_ == OP_ONE) ? OP_ZERO : OP_ONE;
              state_r <= REDUCE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        REDUCE, SQR, MUL: begin
          if (j_r == IDX_ZERO) begin
            p_r <= P_ZERO;
            j_r <= TOP_IDX;
            if (state_r == REDUCE) begin
              bq_r    <= p_next_s[SIZE-1:0];
              state_r <= SQR;
            end else if (state_r == SQR) begin
              t_r     <= p_next_s[SIZE-1:0];
              state_r <= MUL;
            end else begin
              acc_r <= mul_pick_s;
              if (i_r == IDX_ZERO) begin
                result_ <= mul_pick_s;
                done_   <= 1'b1;
                state_r <= DONE;
              end else begin
                i_r     <= i_r - IDX_ONE;
                state_r <= SQR;
              end
            end
          end else begin
            p_r <= p_next_s;
            j_r <= j_r - IDX_ONE;
          end
        end
        DONE: begin
          done_   <= 1'b0;
          busy_   <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_   <= 1'b0;
          busy_   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mod_exp_engine.md
# mod_exp_engine

Sequential modular exponentiation engine computing result = base^exp mod modulus for SIZE-bit operands. It is the compute stage directly upstream of the LED output selector: `result_` (ciphertext/plaintext) feeds the selector's first data input and `msg_` (the latched input message) feeds its second, so the switches choose between showing the input and the transformed value. Run time is constant: every exponent bit costs a square and a multiply, whatever its value.

## Interface

Parameters:
- SIZE, 4, operand width in bits for base, exponent, modulus and result (≥2).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- start_  input  1  request pulse; sampled only in IDLE.
- base_  input  SIZE  message/base operand.
- exp_  input  SIZE  exponent (e or d).
- mod_  input  SIZE  modulus n.
- result_  output  SIZE  base^exp mod modulus; held until next completion.
- msg_  output  SIZE  copy of base_ captured at start acceptance.
- busy_  output  1  high from acceptance until the cycle done_ is high, inclusive.
- done_  output  1  single-cycle completion pulse.
- err_  output  1  set when the accepted modulus was 0; held until next acceptance.

## Operation

- States: IDLE, REDUCE, SQR, MUL, DONE.
- IDLE: on an edge with start_=1, capture base_, exp_, mod_ into internal registers; msg_ ← base_; clear err_. If mod_=0 → DONE with err_=1, result_=0. Otherwise acc ← (mod_==1 ? 0 : 1), bit index i ← SIZE-1, → REDUCE.
- Modular multiply MM(a,b) with b<m: SIZE steps, one per cycle, j from SIZE-1 down to 0: P ← 2P; if P≥m then P ← P−m; if a[j] then P ← P+b; if P≥m then P ← P−m. P starts at 0, is SIZE+1 bits wide, and never exceeds 2m−1 before any subtraction. When the comparison fails, no subtraction is made.
- REDUCE: bq ← MM(base, 1), so bq = base mod m. This handles base ≥ modulus. Lasts SIZE cycles, then → SQR.
- SQR: t ← MM(acc, acc) over SIZE cycles, then → MUL.
- MUL: u ← MM(t, bq) over SIZE cycles. acc ← exp[i] ? u : t. If i=0 → DONE; else i ← i−1 and → SQR.
- DONE: result_ ← acc (or 0 on error), done_=1 for that cycle. Next edge → IDLE.
- start_ is ignored outside IDLE, including during DONE.
- Operand inputs may change freely after acceptance.
- rst low at any time: immediately force IDLE, and drive result_, msg_, busy_, done_, err_ and all internal registers to 0. An aborted operation produces no done_.

## Timing

- Reset values: result_=0, msg_=0, busy_=0, done_=0, err_=0, state IDLE.
- Start accepted at edge k. busy_ is high after edge k.
- Normal path: DONE is entered at edge L = k + SIZE + 2·SIZE². For SIZE=4, L = k+36.
  - result_ and done_ update at edge L.
  - done_ and busy_ fall at edge L+1.
  - A new start_ can be accepted at edge L+1 at the earliest.
- Error path (mod_=0): L = k. done_, err_ and busy_ are high for the single cycle after edge k.
- Latency is independent of the operand values.
- msg_ updates at edge k. result_ is unchanged from edge k until edge L.

## Test plan

- SIZE=4, base=7, exp=3, mod=13, one start_ pulse:
  - done_ high exactly 36 cycles after acceptance, result_=5, msg_=7, err_=0.
  - busy_ high for 37 cycles.
- base=2, exp=15, mod=15: result_=8. base=9, exp=0, mod=11: result_=1. Back-to-back starts, each issued on the cycle after done_.
- Base larger than modulus, and modulus=1:
  - base=15, exp=2, mod=7: result_=1.
  - base=5, exp=3, mod=1: result_=0.
- mod=0, base=6: done_ and err_ high one cycle after acceptance, result_=0. The next valid start clears err_.
- start_ held high throughout, base=3, exp=5, mod=7:
  - only one accept per IDLE; result_=5.
  - operand inputs changed mid-run do not alter the result.
- Reset mid-operation: rst low at k+10 (asynchronous, between edges).
  - All outputs go to 0 immediately and no done_ follows.
  - After rst goes high, 7^3 mod 13 completes with 5.
